// File: rtl/prbs8_checker.sv
// prbs8_checker: receive-side checker for the 8-bit LFSR pattern generator.
//
// The checker samples the serial stream returned by the SISO chain and locks onto
// the PRBS by itself. Once locked it runs the sequence on its own (flywheel),
// flags every bit that differs from its prediction, counts those errors and
// reports loss of sync.
//
// Ports:
//   CLK        in   clock, rising edge
//   RESET      in   asynchronous active-high reset
//   EN         in   bit-valid strobe; D_IN is consumed only when EN=1
//   D_IN       in   received serial bit
//   CLR_CNT    in   synchronous clear of ERR_COUNT
//   LOCKED     out  high while locked
//   ERR        out  one-cycle pulse on each mismatching bit while locked
//   SYNC_LOSS  out  one-cycle pulse when lock is dropped
//   ERR_COUNT  out  saturating count of ERR pulses
//   PERIOD     out  only with PRBS8_CHECKER_PERIOD_EN: pulses when the locked
//                   history reaches 8'h01, which marks the generator's period start
//
// Optional feature macro: PRBS8_CHECKER_PERIOD_EN (adds the PERIOD output).

module prbs8_checker #(
  parameter logic [7:0]  TAPS        = 8'hB8,
  parameter int unsigned VERIFY_LEN  = 16,
  parameter int unsigned WINDOW_LEN  = 32,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             D_IN,
  input  logic             CLR_CNT,
  output logic             LOCKED,
  output logic             ERR,
  output logic             SYNC_LOSS,
  output logic [ERR_W-1:0] ERR_COUNT
`ifdef PRBS8_CHECKER_PERIOD_EN
  ,
  output logic             PERIOD
`endif
);

  localparam logic [7:0] VerifyLen  = 8'(VERIFY_LEN);
  localparam logic [7:0] WindowLen  = 8'(WINDOW_LEN);
  localparam logic [7:0] LossThresh = 8'(LOSS_THRESH);

  typedef enum logic [1:0] {
    StFill   = 2'd0,
    StVerify = 2'd1,
    StLock   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       s_q, s_d;
  // Fill counter in StFill, good-prediction counter in StVerify.
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       win_cnt_q, win_cnt_d;
  logic [7:0]       win_err_q, win_err_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             sync_loss_q, sync_loss_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic       pred;
  logic       mismatch;
  logic [7:0] win_cnt_inc;
  logic [7:0] win_err_inc;

  assign pred        = ^(s_q & TAPS);
  assign mismatch    = D_IN ^ pred;
  assign win_cnt_inc = win_cnt_q + 8'd1;
  assign win_err_inc = win_err_q + {7'd0, mismatch};

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_d       = 1'b0;
    sync_loss_d = 1'b0;

    if (EN) begin
      unique case (state_q)
        StFill: begin
          s_d = {s_q[6:0], D_IN};
          if (cnt_q == 8'd7) begin
            state_d = StVerify;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end

        StVerify: begin
          s_d = {s_q[6:0], D_IN};
          // An all-zero history predicts zeros forever, so it never counts as good.
          if (!mismatch && (s_q != 8'h00)) begin
            if (cnt_q == VerifyLen - 8'd1) begin
              state_d   = StLock;
              cnt_d     = 8'd0;
              win_cnt_d = 8'd0;
              win_err_d = 8'd0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            cnt_d = 8'd0;
          end
        end

        StLock: begin
          // Flywheel: the prediction, not the line bit, enters the history.
          s_d   = {s_q[6:0], pred};
          err_d = mismatch;
          if (win_err_inc == LossThresh) begin
            sync_loss_d = 1'b1;
            state_d     = StFill;
            s_d         = 8'h00;
            cnt_d       = 8'd0;
            win_cnt_d   = 8'd0;
            win_err_d   = 8'd0;
          end else if (win_cnt_inc == WindowLen) begin
            win_cnt_d = 8'd0;
            win_err_d = 8'd0;
          end else begin
            win_cnt_d = win_cnt_inc;
            win_err_d = win_err_inc;
          end
        end

        default: begin
          state_d = StFill;
          s_d     = 8'h00;
          cnt_d   = 8'd0;
        end
      endcase
    end

    locked_d = (state_d == StLock);

    // A clear that coincides with an error leaves exactly that error counted.
    if (CLR_CNT) begin
      err_cnt_d    = '0;
      err_cnt_d[0] = err_d;
    end else if (err_d && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StFill;
      s_q         <= 8'h00;
      cnt_q       <= 8'd0;
      win_cnt_q   <= 8'd0;
      win_err_q   <= 8'd0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      sync_loss_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      sync_loss_q <= sync_loss_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign LOCKED    = locked_q;
  assign ERR       = err_q;
  assign SYNC_LOSS = sync_loss_q;
  assign ERR_COUNT = err_cnt_q;

`ifdef PRBS8_CHECKER_PERIOD_EN
  logic period_q, period_d;

  // s_d is cleared on loss of sync, so a dropping bit never marks a period.
  assign period_d = EN && (state_q == StLock) && (s_d == 8'h01);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      period_q <= 1'b0;
    end else begin
      period_q <= period_d;
    end
  end

  assign PERIOD = period_q;
`endif

endmodule

// File: tb/tb_prbs8_checker.sv
// tb_prbs8_checker: self-checking bench for prbs8_checker.
// A reference PRBS generator (bit recurrence over a history queue) produces the
// line stream; a scenario-level model tracks acquisition length, observation
// windows and the error count to predict every output after each clock edge.

module tb_prbs8_checker;

  localparam int unsigned ErrW   = 4;
  localparam int unsigned MaxCnt = (1 << ErrW) - 1;

  logic            CLK = 1'b0;
  logic            RESET = 1'b0;
  logic            EN = 1'b0;
  logic            D_IN = 1'b0;
  logic            CLR_CNT = 1'b0;
  logic            LOCKED;
  logic            ERR;
  logic            SYNC_LOSS;
  logic [ErrW-1:0] ERR_COUNT;
  logic            period_obs;

  int checks = 0;
  int errors = 0;

  prbs8_checker #(
    .TAPS        (8'hB8),
    .VERIFY_LEN  (16),
    .WINDOW_LEN  (32),
    .LOSS_THRESH (4),
    .ERR_W       (ErrW)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .EN        (EN),
    .D_IN      (D_IN),
    .CLR_CNT   (CLR_CNT),
    .LOCKED    (LOCKED),
    .ERR       (ERR),
    .SYNC_LOSS (SYNC_LOSS),
    .ERR_COUNT (ERR_COUNT)
`ifdef PRBS8_CHECKER_PERIOD_EN
    ,
    .PERIOD    (period_obs)
`endif
  );

`ifndef PRBS8_CHECKER_PERIOD_EN
  assign period_obs = 1'b0;
`endif

  always #5 CLK = ~CLK;

  // ---------------- reference generator ----------------
  bit [7:0] taps = 8'hB8;
  bit       hist[$];  // line bits, oldest first; last entry is the newest

  function automatic void gen_seed();
    hist = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  endfunction

  // New bit = XOR of the bits k+1 positions back for every tap k.
  function automatic bit gen_next();
    bit nb = 1'b0;
    for (int k = 0; k < 8; k++)
      if (taps[k]) nb ^= hist[hist.size() - 1 - k];
    hist.push_back(nb);
    void'(hist.pop_front());
    return nb;
  endfunction

  function automatic bit [7:0] gen_state();
    bit [7:0] s;
    for (int k = 0; k < 8; k++) s[k] = hist[7 - k];
    return s;
  endfunction

  // ---------------- scenario model ----------------
  bit m_locked, m_err, m_sync, m_period;
  int m_acq, m_wpos, m_werr, m_cnt;

  function automatic void model_reset();
    m_locked = 0; m_err = 0; m_sync = 0; m_period = 0;
    m_acq = 0; m_wpos = 0; m_werr = 0; m_cnt = 0;
    gen_seed();
  endfunction

  function automatic logic [ErrW+3:0] obs_vec();
    return {LOCKED, ERR, SYNC_LOSS, period_obs, ERR_COUNT};
  endfunction

  function automatic logic [ErrW+3:0] exp_vec();
    logic [ErrW-1:0] c = ErrW'(m_cnt);
    return {m_locked, m_err, m_sync, m_period, c};
  endfunction

  // One cycle of stimulus plus model update; comparisons are left to the tests.
  // Line errors are only injected while the model is locked.
  task automatic step(input bit en, input bit flip, input bit clr);
    bit rb;
    bit f;
    f  = flip && en && m_locked;
    rb = en ? gen_next() : 1'b0;
    EN      = en;
    D_IN    = en ? (rb ^ f) : 1'($urandom);
    CLR_CNT = clr;
    @(posedge CLK);
    #1;
    m_err = 0; m_sync = 0; m_period = 0;
    if (en) begin
      if (!m_locked) begin
        m_acq++;
        if (m_acq == 24) begin
          m_locked = 1; m_wpos = 0; m_werr = 0;
        end
      end else begin
        m_wpos++;
        if (f) begin
          m_err = 1;
          m_werr++;
        end
        if (m_werr == 4) begin
          m_sync = 1; m_locked = 0; m_acq = 0;
        end else begin
          if (m_wpos == 32) begin
            m_wpos = 0; m_werr = 0;
          end
`ifdef PRBS8_CHECKER_PERIOD_EN
          m_period = (gen_state() == 8'h01);
`endif
        end
      end
    end
    if (clr) m_cnt = m_err ? 1 : 0;
    else if (m_err && m_cnt != MaxCnt) m_cnt++;
  endtask

  task automatic do_reset();
    EN = 0; CLR_CNT = 0;
    RESET = 1;
    @(posedge CLK);
    #1;
    RESET = 0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    EN = 0; CLR_CNT = 0;
    RESET = 1;
    #2;
    checks++;
    if (obs_vec() !== '0) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", obs_vec(), '0);
    end
    @(posedge CLK);
    #1;
    RESET = 0;
    model_reset();
  endtask

  task automatic test_clean_lock();
    int first_lock = 0;
    do_reset();
    for (int i = 0; i < 524; i++) begin
      step(1, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL clean_lock bit %0d: got %b want %b", i + 1, obs_vec(), exp_vec());
      end
      if (LOCKED && first_lock == 0) first_lock = i + 1;
    end
    checks++;
    if (first_lock !== 24) begin
      errors++;
      $display("FAIL clean_lock_edge: got %0d want 24", first_lock);
    end
  endtask

  task automatic test_isolated_errors();
    int off = $urandom_range(0, 10);
    int n_err = 0;
    int n_sync = 0;
    for (int i = 0; i < 140; i++) begin
      step(1, (i >= off) && ((i - off) % 40 == 0) && (i - off < 120), 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL isolated bit %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      n_err += int'(ERR);
      n_sync += int'(SYNC_LOSS);
    end
    checks++;
    if (n_err !== 3 || n_sync !== 0 || ERR_COUNT !== 4'd3 || LOCKED !== 1'b1) begin
      errors++;
      $display("FAIL isolated_summary: got err=%0d sync=%0d cnt=%0d lock=%b want 3 0 3 1",
               n_err, n_sync, ERR_COUNT, LOCKED);
    end
  endtask

  task automatic test_sync_loss();
    int base;
    int n_err = 0;
    int n_sync = 0;
    int since_loss = -1;
    int relock = 0;
    do_reset();
    // Acquire, then move to the start of an observation window.
    for (int i = 0; i < 24; i++) step(1, 0, 0);
    while (m_wpos != 0) step(1, 0, 0);
    base = $urandom_range(0, 3);
    for (int i = 0; i < 90; i++) begin
      step(1, (i == base) || (i == base + 7) || (i == base + 15) || (i == base + 27), 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL sync_loss bit %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      n_err += int'(ERR);
      n_sync += int'(SYNC_LOSS);
      if (since_loss >= 0) since_loss++;
      if (SYNC_LOSS) since_loss = 0;
      if (since_loss > 0 && LOCKED && relock == 0) relock = since_loss;
    end
    checks++;
    if (n_err !== 4 || n_sync !== 1 || relock !== 24 || ERR_COUNT !== 4'd4) begin
      errors++;
      $display("FAIL sync_loss_summary: got err=%0d sync=%0d relock=%0d cnt=%0d want 4 1 24 4",
               n_err, n_sync, relock, ERR_COUNT);
    end
  endtask

  task automatic test_all_zero();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      EN = 1; D_IN = 0; CLR_CNT = 0;
      @(posedge CLK);
      #1;
      checks++;
      if (LOCKED !== 1'b0 || ERR !== 1'b0) begin
        errors++;
        $display("FAIL all_zero bit %0d: got lock=%b err=%b want 0 0", i, LOCKED, ERR);
      end
    end
    EN = 0;
  endtask

  task automatic test_en_gaps();
    int consumed = 0;
    int lock_at = 0;
    do_reset();
    for (int i = 0; i < 120; i++) begin
      step(i % 3 == 0, 0, 0);
      if (i % 3 == 0) consumed++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL en_gaps cycle %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      if (LOCKED && lock_at == 0) lock_at = consumed;
    end
    checks++;
    if (lock_at !== 24) begin
      errors++;
      $display("FAIL en_gaps_lock: got %0d consumed want 24", lock_at);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 240; i++) begin
      step(1, i % 12 == 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL saturation bit %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (ERR_COUNT !== 4'hF || LOCKED !== 1'b1) begin
      errors++;
      $display("FAIL saturation_hold: got cnt=%h lock=%b want f 1", ERR_COUNT, LOCKED);
    end
  endtask

  task automatic test_clr_with_err();
    step(1, 1, 1);
    checks++;
    if (ERR_COUNT !== 4'd1 || ERR !== 1'b1) begin
      errors++;
      $display("FAIL clr_with_err: got cnt=%0d err=%b want 1 1", ERR_COUNT, ERR);
    end
    step(1, 0, 1);
    checks++;
    if (ERR_COUNT !== 4'd0) begin
      errors++;
      $display("FAIL clr_plain: got %0d want 0", ERR_COUNT);
    end
  endtask

  task automatic test_async_reset();
    // Bring up a lock with a non-zero count, then reset between edges.
    for (int i = 0; i < 8; i++) step(1, i == 2, 0);
    #2;
    RESET = 1;
    #1;
    checks++;
    if (obs_vec() !== '0) begin
      errors++;
      $display("FAIL async_reset: got %b want %b", obs_vec(), '0);
    end
    @(posedge CLK);
    #1;
    RESET = 0;
    model_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cycle %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_lock();
    test_isolated_errors();
    test_sync_loss();
    test_all_zero();
    test_en_gaps();
    test_saturation();
    test_clr_with_err();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
